// File: rtl/vga_pkg.sv
// Shared constants for the VGA rectangle fill engine.
//   Frame geometry (160x120 logical pixels), bus widths, fill FSM state
//   encoding and small helpers for clamping and row-base computation.
package vga_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;

    localparam logic [X_W-1:0]    X_MAX      = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]    Y_MAX      = Y_W'(SCREEN_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);

    // Fill FSM state encoding
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] StIdle  = 3'd0;
    localparam logic [ST_W-1:0] StSetup = 3'd1;
    localparam logic [ST_W-1:0] StWrite = 3'd2;
    localparam logic [ST_W-1:0] StGap   = 3'd3;
    localparam logic [ST_W-1:0] StDone  = 3'd4;

    // y*160 as (y<<7)+(y<<5); max 119*160 = 19040, fits ADDR_W.
    function automatic logic [ADDR_W-1:0] row_base_of(input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] y_ext;
        y_ext = ADDR_W'(y);
        return (y_ext << 7) + (y_ext << 5);
    endfunction

    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x);
        return (x > X_MAX) ? X_MAX : x;
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
        return (y > Y_MAX) ? Y_MAX : y;
    endfunction

endpackage

// File: rtl/vga_rect_filler_if.sv
// Command and video-memory write bus of the rectangle fill engine.
//   master : command source / write-port consumer (drives cmd_*)
//   slave  : the fill engine (drives cmd_ready, busy, done and the write port)
interface vga_rect_filler_if;
    import vga_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x0;
    logic [X_W-1:0]     cmd_x1;
    logic [Y_W-1:0]     cmd_y0;
    logic [Y_W-1:0]     cmd_y1;
    logic [COLOR_W-1:0] cmd_color;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  data_addr;
    logic [COLOR_W-1:0] data_in;
    logic               write_enable;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        input  cmd_ready, busy, done, data_addr, data_in, write_enable
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        output cmd_ready, busy, done, data_addr, data_in, write_enable
    );

endinterface

// File: rtl/rect_raster_counter.sv
// Raster-order pixel stepper for one rectangle.
//   clk, rst_n        : clock, async active-low reset
//   load              : latch bounds and start at (x_start, y_start)
//   step              : advance to the next pixel in raster order
//   x_start/x_end     : clamped column bounds (inclusive)
//   y_start/y_end     : clamped row bounds (inclusive)
//   next_addr         : address of the pixel the counter will hold after this edge
//   last_pixel        : current pixel is the bottom-right corner
module rect_raster_counter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [X_W-1:0]    x_start,
    input  logic [X_W-1:0]    x_end,
    input  logic [Y_W-1:0]    y_start,
    input  logic [Y_W-1:0]    y_end,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last_pixel
);

    logic [X_W-1:0]    x_q, x_d, x0_q, x1_q;
    logic [Y_W-1:0]    y_q, y_d, y1_q;
    logic [ADDR_W-1:0] row_q, row_d;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        row_d = row_q;
        if (load) begin
            x_d   = x_start;
            y_d   = y_start;
            row_d = row_base_of(y_start);
        end else if (step) begin
            if (x_q == x1_q) begin
                x_d   = x0_q;
                y_d   = y_q + Y_W'(1);
                row_d = row_q + ROW_STRIDE;
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    // Exposing the next-state address lets the owner register it on the same
    // edge the counter moves, so the write port stays fully registered.
    assign next_addr  = row_d + ADDR_W'(x_d);
    assign last_pixel = (x_q == x1_q) && (y_q == y1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            row_q <= '0;
            x0_q  <= '0;
            x1_q  <= '0;
            y1_q  <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            row_q <= row_d;
            if (load) begin
                x0_q <= x_start;
                x1_q <= x_end;
                y1_q <= y_end;
            end
        end
    end

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine for the VGA controller's video memory.
//   Accepts one fill command (inclusive corners + colour) and emits one
//   single-cycle pixel write per pixel in raster order, each followed by
//   WR_GAP idle cycles so the controller can finish its read-modify-write.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of vga_rect_filler_if (command handshake,
//                busy/done status, data_addr/data_in/write_enable port)
module vga_rect_filler
    import vga_pkg::*;
#(
    parameter int unsigned WR_GAP = 1
) (
    input logic              clk,
    input logic              rst_n,
    vga_rect_filler_if.slave bus
);

    localparam int unsigned GapW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(WR_GAP - 1);

    logic [ST_W-1:0]    state_q, state_d;
    logic [GapW-1:0]    gap_q, gap_d;

    logic [X_W-1:0]     x0_q, x1_q;
    logic [Y_W-1:0]     y0_q, y1_q;
    logic [COLOR_W-1:0] color_q;

    logic               cmd_ready_q, busy_q, done_q, we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COLOR_W-1:0] data_q;

    logic               accept;
    logic               load, step;
    logic               empty;
    logic [X_W-1:0]     x0_c, x1_c;
    logic [Y_W-1:0]     y0_c, y1_c;
    logic [ADDR_W-1:0]  next_addr;
    logic               last_pixel;

    assign accept = bus.cmd_valid && (state_q == StIdle);

    assign x0_c  = clamp_x(x0_q);
    assign x1_c  = clamp_x(x1_q);
    assign y0_c  = clamp_y(y0_q);
    assign y1_c  = clamp_y(y1_q);
    assign empty = (x0_c > x1_c) || (y0_c > y1_c);

    rect_raster_counter u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .step       (step),
        .x_start    (x0_c),
        .x_end      (x1_c),
        .y_start    (y0_c),
        .y_end      (y1_c),
        .next_addr  (next_addr),
        .last_pixel (last_pixel)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (empty) begin
                    state_d = StDone;
                end else begin
                    load    = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    if (last_pixel) begin
                        state_d = StDone;
                    end else begin
                        step    = 1'b1;
                        state_d = StWrite;
                    end
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Command is captured on accept so cmd_* may change during the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (accept) begin
            x0_q    <= bus.cmd_x0;
            x1_q    <= bus.cmd_x1;
            y0_q    <= bus.cmd_y0;
            y1_q    <= bus.cmd_y1;
            color_q <= bus.cmd_color;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            cmd_ready_q <= (state_d == StIdle);
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
            we_q        <= (state_d == StWrite);
            if (state_d == StWrite) begin
                addr_q <= next_addr;
                data_q <= color_q;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.write_enable = we_q;
    assign bus.data_addr    = addr_q;
    assign bus.data_in      = data_q;

endmodule
